// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory: access-size codes,
// controller states and the elaboration-time helpers used by the datapath.
`timescale 1ns/1ps
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) result = i + 1;
            else result = result;
        end
        return result;
    endfunction

    // Even parity: the stored bit makes the 9-bit group carry an even number of ones.
    function automatic logic byte_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enables and data positioning,
// plus load extraction with zero/sign extension.
`timescale 1ns/1ps
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = DATA_W / 8,
    parameter int OFF_W  = clog2(LANES)
) (
    input  logic [1:0]        size_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [DATA_W-1:0] rd_word_i,
    output logic [LANES-1:0]  be_o,
    output logic [DATA_W-1:0] wr_word_o,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [7:0]        nbytes_s;
    logic [DATA_W-1:0] shifted_s;
    logic              sign_s;

    // Access size in bytes, clamped so oversize codes never index past the word
    always_comb begin
        case (size_i)
            SIZE_B:  nbytes_s = 8'd1;
            SIZE_H:  nbytes_s = 8'd2;
            SIZE_W:  nbytes_s = 8'd4;
            SIZE_D:  nbytes_s = 8'd8;
            default: nbytes_s = 8'd1;
        endcase
        if (int'(nbytes_s) > LANES) nbytes_s = 8'(LANES);
        else nbytes_s = nbytes_s;
    end

    // Byte-enable window starting at the lane offset
    always_comb begin
        be_o = '0;
        for (int l = 0; l < LANES; l++) begin
            if ((l >= int'(off_i)) && (l < int'(off_i) + int'(nbytes_s))) be_o[l] = 1'b1;
            else be_o[l] = 1'b0;
        end
    end

    assign wr_word_o = wr_data_i << {off_i, 3'b000};
    assign shifted_s = rd_word_i >> {off_i, 3'b000};

    // Most significant bit of the accessed field
    always_comb begin
        sign_s = 1'b0;
        for (int b = 0; b < DATA_W; b++) begin
            if (b == 8 * int'(nbytes_s) - 1) sign_s = shifted_s[b];
            else sign_s = sign_s;
        end
    end

    // Keep the accessed bytes, fill the rest with zero or the sign bit
    always_comb begin
        rd_data_o = '0;
        for (int b = 0; b < DATA_W; b++) begin
            if (b < 8 * int'(nbytes_s)) rd_data_o[b] = shifted_s[b];
            else rd_data_o[b] = sign_s & signed_i;
        end
    end

endmodule

// File: rtl/dmem_unit.sv
// Data memory with zero-fill initialisation and a fixed one-cycle response.
// Define DMEM_PARITY_EN to add per-byte even parity storage and load checking.
`timescale 1ns/1ps
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqWrData,
    output logic              RspValid,
    output logic [DATA_W-1:0] RspRdData,
    output logic              RspErr,
    output logic              ParityErr
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = clog2(LANES);
    localparam int IDX_W = clog2(DEPTH);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              ready_s, init_we_s, accept_s, wr_en_s;
    logic              misalign_s, size_bad_s, range_bad_s, err_s, par_mis_s;
    logic [IDX_W-1:0]  idx_s;
    logic [OFF_W-1:0]  off_s;
    logic [LANES-1:0]  be_s;
    logic [DATA_W-1:0] wr_word_s, rd_word_s, rd_data_s;

    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, par_err_q, par_err_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    // Controller state and zero-fill counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // INIT walks every word once, then settles in IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
                else state_d = ST_INIT;
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Controller outputs
    always_comb begin
        ready_s   = 1'b0;
        init_we_s = 1'b0;
        case (state_q)
            ST_INIT: init_we_s = 1'b1;
            ST_IDLE: ready_s   = 1'b1;
            default: begin
                ready_s   = 1'b0;
                init_we_s = 1'b0;
            end
        endcase
    end

    assign ReqReady = ready_s & ~Reset;
    assign accept_s = ReqValid & ReqReady;
    assign idx_s    = ReqAddr[OFF_W+IDX_W-1:OFF_W];
    assign off_s    = ReqAddr[OFF_W-1:0];
    assign rd_word_s = mem_q[idx_s];

    // Natural alignment check for the requested size
    always_comb begin
        case (ReqSize)
            SIZE_B:  misalign_s = 1'b0;
            SIZE_H:  misalign_s = ReqAddr[0];
            SIZE_W:  misalign_s = |ReqAddr[1:0];
            SIZE_D:  misalign_s = |ReqAddr[2:0];
            default: misalign_s = 1'b1;
        endcase
    end

    assign size_bad_s  = 32'(ReqSize) > 32'(OFF_W);
    assign range_bad_s = (ReqAddr >> OFF_W) >= ADDR_W'(DEPTH);
    assign err_s       = size_bad_s | misalign_s | range_bad_s;
    assign wr_en_s     = accept_s & ReqWrite & ~err_s;

    dmem_lane_align #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .OFF_W  (OFF_W)
    ) u_align (
        .size_i    (ReqSize),
        .off_i     (off_s),
        .signed_i  (ReqSigned),
        .wr_data_i (ReqWrData),
        .rd_word_i (rd_word_s),
        .be_o      (be_s),
        .wr_word_o (wr_word_s),
        .rd_data_o (rd_data_s)
    );

    // Storage: zero-fill during INIT, byte-masked stores afterwards
    always_ff @(posedge Clk) begin
        if (init_we_s) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en_s) begin
            for (int l = 0; l < LANES; l++) begin
                if (be_s[l]) mem_q[idx_s][8*l +: 8] <= wr_word_s[8*l +: 8];
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [LANES-1:0] par_q [DEPTH];

    // Parity bits follow the data writes lane for lane
    always_ff @(posedge Clk) begin
        if (init_we_s) begin
            par_q[cnt_q] <= '0;
        end else if (wr_en_s) begin
            for (int l = 0; l < LANES; l++) begin
                if (be_s[l]) par_q[idx_s][l] <= byte_parity(wr_word_s[8*l +: 8]);
            end
        end
    end

    // Only the lanes the load touches are checked
    always_comb begin
        par_mis_s = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (be_s[l] && (byte_parity(rd_word_s[8*l +: 8]) != par_q[idx_s][l])) par_mis_s = 1'b1;
            else par_mis_s = par_mis_s;
        end
    end
`else
    assign par_mis_s = 1'b0;
`endif

    // Response contents captured at the accept edge
    always_comb begin
        rsp_valid_d = accept_s;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        par_err_d   = 1'b0;
        if (accept_s && !err_s && !ReqWrite) begin
            rsp_data_d = rd_data_s;
            par_err_d  = par_mis_s;
        end else begin
            rsp_err_d  = accept_s & err_s;
        end
    end

    // Response registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            par_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            par_err_q   <= par_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // A response still in flight when Reset rises is suppressed immediately
    assign RspValid  = rsp_valid_q & ~Reset;
    assign RspErr    = rsp_err_q & ~Reset;
    assign ParityErr = par_err_q & ~Reset;
    assign RspRdData = Reset ? '0 : rsp_data_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: byte-array reference model, per-cycle
// comparison, directed literal checks and a randomized request phase.
`timescale 1ns/1ps
module tb_dmem_unit;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;
    localparam int LANES  = 4;
    localparam int OFF_W  = 2;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              ReqValid = 1'b0;
    logic              ReqWrite = 1'b0;
    logic [1:0]        ReqSize = 2'd0;
    logic              ReqSigned = 1'b0;
    logic [ADDR_W-1:0] ReqAddr = '0;
    logic [DATA_W-1:0] ReqWrData = '0;
    logic              ReqReady, RspValid, RspErr, ParityErr;
    logic [DATA_W-1:0] RspRdData;

    dmem_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned),
        .ReqAddr(ReqAddr), .ReqWrData(ReqWrData), .RspValid(RspValid),
        .RspRdData(RspRdData), .RspErr(RspErr), .ParityErr(ParityErr)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: flat byte array, init countdown, one pending response
    byte unsigned    m_mem [DEPTH*LANES];
    bit              m_bad [DEPTH*LANES];
    int              m_init_left = 0;
    bit              m_live = 1'b0;
    bit              e_valid = 1'b0, e_err = 1'b0, e_perr = 1'b0;
    longint unsigned e_data = 0;

    task automatic model_req();
        longint unsigned a, w, v;
        int sz, nb, off, base;
        bit err, bad;
        a   = longint'(ReqAddr);
        sz  = int'(ReqSize);
        nb  = 1 << sz;
        off = int'(a % LANES);
        w   = a / LANES;
        err = (sz > OFF_W) || ((a % nb) != 0) || (w >= DEPTH);
        e_valid = 1'b1;
        e_err   = err;
        if (!err) begin
            base = int'(w) * LANES + off;
            if (ReqWrite) begin
                for (int k = 0; k < nb; k++) begin
                    m_mem[base+k] = 8'((ReqWrData >> (8*k)) & 32'hFF);
                    m_bad[base+k] = 1'b0;
                end
            end else begin
                v = 0;
                bad = 1'b0;
                for (int k = 0; k < nb; k++) begin
                    v = v | (longint'(m_mem[base+k]) << (8*k));
                    bad = bad | m_bad[base+k];
                end
                if (ReqSigned && m_mem[base+nb-1][7]) v = v | (~64'd0 << (8*nb));
                e_data = v & 64'hFFFF_FFFF;
                e_perr = bad;
            end
        end
    endtask

    always @(posedge Clk) begin
        if (Reset) begin
            m_live = 1'b1;
            m_init_left = DEPTH;
            e_valid = 1'b0; e_err = 1'b0; e_perr = 1'b0; e_data = 0;
            for (int i = 0; i < DEPTH*LANES; i++) begin
                m_mem[i] = 8'd0;
                m_bad[i] = 1'b0;
            end
        end else begin
            e_valid = 1'b0; e_err = 1'b0; e_perr = 1'b0; e_data = 0;
            if (m_init_left > 0) m_init_left = m_init_left - 1;
            else if (ReqValid) model_req();
        end
    end

    // Per-cycle comparison of every output against the model
    logic [35:0] got_v, exp_v;
    logic        ev;
    always @(negedge Clk) begin
        if (m_live) begin
            ev    = e_valid && !Reset;
            exp_v = {(m_init_left == 0) && !Reset, ev, ev && e_err, ev && e_perr,
                     ev ? e_data[31:0] : 32'd0};
            got_v = {ReqReady, RspValid, RspErr, ParityErr, RspRdData};
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t got rdy/vld/err/perr/data=%h required %h",
                         $time, got_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input longint unsigned got, input longint unsigned want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h required %h", name, got, want);
        end
    endtask

    task automatic req(input bit w, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd);
        ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg;
        ReqAddr = a; ReqWrData = wd;
        @(posedge Clk);
        #1 ReqValid = 1'b0;
    endtask

    task automatic expect_rsp(input string name, input bit err, input logic [31:0] data);
        @(negedge Clk);
        chk(name, {RspValid, RspErr, RspRdData}, {1'b1, err, data});
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        @(negedge Clk);
        while (!ReqReady && n < 600) begin
            n++;
            @(negedge Clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    int n;
    int r, sz, w, off;
    initial begin
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        wait_ready(n);
        chk("init_cycles", n, 256);

        req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
        expect_rsp("load_last_word", 1'b0, 32'h0000_0000);
        req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        expect_rsp("store_rsp_zero", 1'b0, 32'h0000_0000);
        req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        expect_rsp("lb_signed_13", 1'b0, 32'hFFFF_FFDE);
        req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
        expect_rsp("lbu_12", 1'b0, 32'h0000_00AD);
        req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
        expect_rsp("lh_signed_10", 1'b0, 32'hFFFF_BEEF);
        req(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_005A);
        req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        expect_rsp("b2b_load_20", 1'b0, 32'h0000_5A00);
        req(1'b1, 2'd2, 1'b0, 32'h11, 32'h1234_5678);
        expect_rsp("misaligned_store", 1'b1, 32'h0000_0000);
        req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        expect_rsp("word10_unchanged", 1'b0, 32'hDEAD_BEEF);
        req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
        expect_rsp("out_of_range", 1'b1, 32'h0000_0000);
        req(1'b0, 2'd3, 1'b0, 32'h18, 32'h0);
        expect_rsp("size3_err", 1'b1, 32'h0000_0000);

        // Randomized traffic, concentrated on a few words to hit read-after-write
        @(posedge Clk);
        #1;
        for (int i = 0; i < 1500; i++) begin
            r  = int'($urandom_range(0, 9));
            sz = (r == 0) ? 3 : int'($urandom_range(0, 2));
            w  = (r < 6) ? int'($urandom_range(0, 31))
               : (r == 6) ? int'($urandom_range(DEPTH, DEPTH + 40))
               : int'($urandom_range(0, DEPTH - 1));
            off = int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) != 0) off = off & ~((1 << sz) - 1);
            ReqValid  = ($urandom_range(0, 3) != 0);
            ReqWrite  = $urandom_range(0, 1) == 1;
            ReqSigned = $urandom_range(0, 1) == 1;
            ReqSize   = 2'(sz);
            ReqAddr   = 32'(w * 4 + off);
            ReqWrData = 32'($urandom);
            @(posedge Clk);
            #1;
        end
        ReqValid = 1'b0;

`ifdef DMEM_PARITY_EN
        req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        dut.mem_q[4][0] <= ~dut.mem_q[4][0];
        m_mem[16] = m_mem[16] ^ 8'h01;
        m_bad[16] = 1'b1;
        #1;
        req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
        @(negedge Clk);
        chk("parity_flip", {RspValid, RspErr, ParityErr, RspRdData},
            {1'b1, 1'b0, 1'b1, 32'h0000_00EE});
`endif

        // Reset right after a load accept drops the response and reruns INIT
        req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("reset_drops_rsp", RspValid, 0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        wait_ready(n);
        chk("reinit_cycles", n, 256);
        req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        expect_rsp("load10_after_reset", 1'b0, 32'h0000_0000);

        @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_unit.md
DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, word width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter DEPTH, default 256, number of words; it must be a power of two and at least 2.
REQ-003 The block SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 The block SHALL have port Clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit, synchronous and active-high.
REQ-006 The block SHALL have port ReqValid, input, 1 bit, request present.
REQ-007 The block SHALL have port ReqReady, output, 1 bit, block can accept a request.
REQ-008 The block SHALL have port ReqWrite, input, 1 bit: 1 = store, 0 = load.
REQ-009 The block SHALL have port ReqSize, input, 2 bits, log2 of the access size in bytes: 0 = byte, 1 = half, 2 = word32, 3 = word64.
REQ-010 The block SHALL have port ReqSigned, input, 1 bit, sign-extend load data.
REQ-011 The block SHALL have port ReqAddr, input, ADDR_W bits, byte address.
REQ-012 The block SHALL have port ReqWrData, input, DATA_W bits, store data right-aligned.
REQ-013 The block SHALL have port RspValid, output, 1 bit, response strobe.
REQ-014 The block SHALL have port RspRdData, output, DATA_W bits, load data right-aligned and extended.
REQ-015 The block SHALL have port RspErr, output, 1 bit, request rejected.
REQ-016 The block SHALL have port ParityErr, output, 1 bit, parity mismatch on a load; see REQ-032.

Function
REQ-017 The block SHALL define LANES = DATA_W/8 and OFF_W = log2(LANES); the word index is ReqAddr[OFF_W+log2(DEPTH)-1:OFF_W].
REQ-018 The block SHALL have two FSM states, INIT and IDLE: Reset goes to INIT, and INIT goes to IDLE after DEPTH cycles.
REQ-019 In INIT, a counter SHALL zero-fill one word per cycle starting at index 0, with ReqReady = 0.
REQ-020 In IDLE, ReqReady SHALL be 1 and one request SHALL be accepted per cycle on ReqValid && ReqReady; there is no response backpressure.
REQ-021 A store SHALL write only the byte lanes selected by ReqSize and ReqAddr[OFF_W-1:0] at the accept edge, taking the low 2^ReqSize bytes of ReqWrData.
REQ-022 A load SHALL read the selected lanes, shift them to bit 0, and zero- or sign-extend them per ReqSigned.
REQ-023 RspValid SHALL pulse exactly 1 cycle after each accept (fixed latency 1); a store response SHALL carry RspRdData = 0.
REQ-024 A load accepted on the cycle after a store to the same word SHALL return the stored data.
REQ-025 A request SHALL be treated as an error if any of the following holds: ReqSize > OFF_W; the address is misaligned (ReqAddr mod 2^ReqSize != 0); or ReqAddr[ADDR_W-1:OFF_W] >= DEPTH.
REQ-026 An erroring request SHALL perform no write and SHALL respond with RspErr = 1 and RspRdData = 0.
REQ-027 Outside an RspValid cycle, RspRdData, RspErr and ParityErr SHALL be 0.
REQ-028 When Reset is asserted while a response is pending, the response SHALL be dropped: RspValid is 0 on the next cycle and INIT restarts at index 0.

Reset
REQ-029 Reset SHALL force ReqReady = 0, RspValid = 0, RspRdData = 0, RspErr = 0, ParityErr = 0, state = INIT and counter = 0.
REQ-030 Memory contents SHALL be defined only by the INIT zero-fill; there is no file preload.

Configuration
REQ-031 Macro DMEM_PARITY_EN SHALL select the parity feature.
REQ-032 With DMEM_PARITY_EN defined: store one even-parity bit per byte; INIT writes parity 0; a load checks the accessed lanes; a mismatch sets ParityErr = 1 with RspValid while data is still returned and RspErr is unaffected.
REQ-033 Without DMEM_PARITY_EN: no parity storage exists and ParityErr is tied to 0.

Structure
REQ-034 Package dmem_pkg SHALL hold the ReqSize encodings, the FSM state enum, and a clog2 function.
REQ-035 Sub-module dmem_lane_align SHALL be combinational and SHALL provide store byte-enable and lane-shift generation plus load extraction and extension.

Verification (DATA_W=32, DEPTH=256)
REQ-036 Reset for 1 cycle -> ReqReady = 0 for 256 cycles, then 1; a load of word 0x3FC -> 0x00000000.
REQ-037 Store word 0xDEADBEEF @0x10; then load byte signed @0x13 -> 0xFFFFFFDE, byte unsigned @0x12 -> 0x000000AD, half signed @0x10 -> 0xFFFFBEEF.
REQ-038 Back-to-back: store byte 0x5A @0x21, then load word @0x20 on the next cycle -> 0x00005A00.
REQ-039 Error cases:
- Store word @0x11 -> RspErr = 1, and the word @0x10 is unchanged.
- Load @0x400 -> RspErr = 1, RspRdData = 0.
- ReqSize = 3 -> RspErr = 1.
REQ-040 Reset asserted the cycle after a load accept -> RspValid stays 0, INIT reruns, and a later load @0x10 -> 0.
REQ-041 With DMEM_PARITY_EN: a hierarchical flip of stored bit 0 @0x10, then load byte @0x10 -> ParityErr = 1 and RspErr = 0.
